// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: instruction layout, widths and
// FSM states, so the fetch stage, this block and the benches agree.
package prog_mem_pkg;

  localparam int unsigned DEF_VEC_ID_WIDTH       = 3;
  localparam int unsigned DEF_REGFILE_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_ADDR_WIDTH    = 6;
  localparam int unsigned DEF_PROG_SIZE          = 32;

  function automatic int unsigned instr_width(input int unsigned vec_w,
                                              input int unsigned reg_w,
                                              input int unsigned dat_w);
    return 2 + vec_w + 2 * reg_w + 3 * dat_w;
  endfunction

  // Field LSB offsets for the default layout, MSB first:
  // lstg_f | upse_f | vector_id | result_reg | error_reg | data_a | data_b | coef
  localparam int unsigned COEF_PTR_LSB   = 0;
  localparam int unsigned DATA_PTR_B_LSB = COEF_PTR_LSB + DEF_DATA_ADDR_WIDTH;
  localparam int unsigned DATA_PTR_A_LSB = DATA_PTR_B_LSB + DEF_DATA_ADDR_WIDTH;
  localparam int unsigned ERROR_REG_LSB  = DATA_PTR_A_LSB + DEF_DATA_ADDR_WIDTH;
  localparam int unsigned RESULT_REG_LSB = ERROR_REG_LSB + DEF_REGFILE_ADDR_WIDTH;
  localparam int unsigned VECTOR_ID_LSB  = RESULT_REG_LSB + DEF_REGFILE_ADDR_WIDTH;
  localparam int unsigned UPSE_F_BIT     = VECTOR_ID_LSB + DEF_VEC_ID_WIDTH;
  localparam int unsigned LSTG_F_BIT     = UPSE_F_BIT + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

endpackage

// File: rtl/prog_mem_if.sv
// Load port and instruction-fetch port of the program memory.
interface prog_mem_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned VEC_ID_WIDTH       = DEF_VEC_ID_WIDTH,
  parameter int unsigned REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
  parameter int unsigned DATA_ADDR_WIDTH    = DEF_DATA_ADDR_WIDTH,
  parameter int unsigned PROG_SIZE          = DEF_PROG_SIZE
);
  localparam int unsigned INSTR_WIDTH =
    instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned PC_WIDTH = $clog2(PROG_SIZE);

  logic                   prog;
  logic                   ld_valid;
  logic [INSTR_WIDTH-1:0] ld_word;
  logic                   ld_ready;
  logic                   fetch;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instr_word;
  logic                   instr_valid;
  logic                   addr_err;
  logic [PC_WIDTH:0]      prog_len;
  logic                   loaded;
  logic                   ovf;

  modport master (
    output prog, ld_valid, ld_word, fetch, pc,
    input  ld_ready, instr_word, instr_valid, addr_err, prog_len, loaded, ovf
  );

  modport slave (
    input  prog, ld_valid, ld_word, fetch, pc,
    output ld_ready, instr_word, instr_valid, addr_err, prog_len, loaded, ovf
  );

endinterface

// File: rtl/prog_mem_ram.sv
// Single-port array: synchronous write, registered read that holds its value
// whenever no read is requested.
module prog_mem_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 31,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Program memory responder: word-by-word load while prog is high, then
// single-cycle-latency instruction fetch from the controller.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned VEC_ID_WIDTH       = DEF_VEC_ID_WIDTH,
  parameter int unsigned REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
  parameter int unsigned DATA_ADDR_WIDTH    = DEF_DATA_ADDR_WIDTH,
  parameter int unsigned PROG_SIZE          = DEF_PROG_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  prog_mem_if.slave  bus
);

  localparam int unsigned INSTR_WIDTH =
    instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned PC_WIDTH = $clog2(PROG_SIZE);
  localparam logic [PC_WIDTH:0] FULL = (PC_WIDTH + 1)'(PROG_SIZE);

  state_t state, state_nxt;

  logic [PC_WIDTH:0]      wr_ptr;
  logic [PC_WIDTH:0]      prog_len;
  logic                   loaded;
  logic                   ovf;
  logic                   instr_valid;
  logic                   addr_err;
  logic                   zero_q;
  logic [INSTR_WIDTH-1:0] ram_q;
  logic [PC_WIDTH-1:0]    ram_addr;
  logic                   pc_in_range;

  logic ld_ready, wr_en, rd_en, rd_oor, rd_reject, start_load, end_load, ovf_set;

  assign pc_in_range = {1'b0, bus.pc} < prog_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_oor     = 1'b0;
    rd_reject  = 1'b0;
    start_load = 1'b0;
    end_load   = 1'b0;
    ovf_set    = 1'b0;
    unique case (state)
      S_EMPTY: begin
        rd_reject = bus.fetch;
        if (bus.prog) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        rd_reject = bus.fetch;
        if (bus.prog) begin
          ld_ready = wr_ptr < FULL;
          wr_en    = bus.ld_valid && ld_ready;
          ovf_set  = bus.ld_valid && !ld_ready;
        end else begin
          end_load  = 1'b1;
          state_nxt = (wr_ptr != '0) ? S_READY : S_EMPTY;
        end
      end
      S_READY: begin
        if (bus.prog) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
          rd_reject  = bus.fetch;
        end else if (bus.fetch) begin
          rd_en  = pc_in_range;
          rd_oor = !pc_in_range;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      prog_len    <= '0;
      loaded      <= 1'b0;
      ovf         <= 1'b0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      instr_valid <= rd_en;
      addr_err    <= rd_oor || rd_reject;
      if (rd_en) begin
        zero_q <= 1'b0;
      end else if (rd_oor) begin
        zero_q <= 1'b1;
      end
      if (start_load) begin
        wr_ptr <= '0;
        ovf    <= 1'b0;
        loaded <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (end_load) begin
        prog_len <= wr_ptr;
        loaded   <= (wr_ptr != '0);
      end
    end
  end

  assign ram_addr = (state == S_LOAD) ? wr_ptr[PC_WIDTH-1:0] : bus.pc;

  prog_mem_ram #(
    .DEPTH (PROG_SIZE),
    .WIDTH (INSTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (bus.ld_word),
    .q     (ram_q)
  );

  // The RAM read register has no reset and only updates on in-range reads;
  // zero_q masks it after reset and after an out-of-range fetch.
  assign bus.instr_word  = zero_q ? '0 : ram_q;
  assign bus.ld_ready    = ld_ready;
  assign bus.instr_valid = instr_valid;
  assign bus.addr_err    = addr_err;
  assign bus.prog_len    = prog_len;
  assign bus.loaded      = loaded;
  assign bus.ovf         = ovf;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: vector tables for load/fetch/reload, plus
// hand sequences for mid-load reset and the full/overflow case.
module tb_prog_mem;

  localparam int unsigned IW = 31;
  localparam int unsigned PW = 5;

  typedef struct {
    logic          prog;
    logic          vld;
    logic [IW-1:0] word;
    logic          fetch;
    logic [PW-1:0] pc;
    logic          rdy;
    logic [IW-1:0] iw;
    logic          iv;
    logic          ae;
    logic [PW:0]   plen;
    logic          ld;
    logic          ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  prog_mem_if #(
    .VEC_ID_WIDTH       (3),
    .REGFILE_ADDR_WIDTH (4),
    .DATA_ADDR_WIDTH    (6),
    .PROG_SIZE          (32)
  ) bus ();

  prog_mem #(
    .VEC_ID_WIDTH       (3),
    .REGFILE_ADDR_WIDTH (4),
    .DATA_ADDR_WIDTH    (6),
    .PROG_SIZE          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic prog, input logic vld, input logic [IW-1:0] word,
                              input logic fetch, input logic [PW-1:0] pc, input logic rdy,
                              input logic [IW-1:0] iw, input logic iv, input logic ae,
                              input logic [PW:0] plen, input logic ld, input logic ovf);
    vec_t v;
    v.prog = prog; v.vld = vld; v.word = word; v.fetch = fetch; v.pc = pc;
    v.rdy = rdy; v.iw = iw; v.iv = iv; v.ae = ae; v.plen = plen; v.ld = ld; v.ovf = ovf;
    return v;
  endfunction

  task automatic drive(input logic prog, input logic vld, input logic [IW-1:0] word,
                       input logic fetch, input logic [PW-1:0] pc);
    @(negedge clk);
    bus.prog = prog; bus.ld_valid = vld; bus.ld_word = word; bus.fetch = fetch; bus.pc = pc;
  endtask

  task automatic chk_outs(input string tag, input logic [IW-1:0] iw, input logic iv,
                          input logic ae, input logic [PW:0] plen, input logic ld,
                          input logic ovf);
    chk({tag, " instr_word"},  bus.instr_word,  iw);
    chk({tag, " instr_valid"}, bus.instr_valid, iv);
    chk({tag, " addr_err"},    bus.addr_err,    ae);
    chk({tag, " prog_len"},    bus.prog_len,    plen);
    chk({tag, " loaded"},      bus.loaded,      ld);
    chk({tag, " ovf"},         bus.ovf,         ovf);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].prog, vecs[i].vld, vecs[i].word, vecs[i].fetch, vecs[i].pc);
      #1 chk($sformatf("v%0d ld_ready", i), bus.ld_ready, vecs[i].rdy);
      @(posedge clk);
      #1 chk_outs($sformatf("v%0d", i), vecs[i].iw, vecs[i].iv, vecs[i].ae,
                  vecs[i].plen, vecs[i].ld, vecs[i].ovf);
    end
  endtask

  initial begin
    // Table A (0..15): load 1..5, fetch in range, out of range, recovery.
    //              prog vld word   fetch pc   rdy iw      iv ae plen ld ovf
    vecs.push_back(mk(1, 0, 31'h0, 0, 5'd0,  0, 31'h0, 0, 0, 6'd0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(1, 1, IW'(k), 0, 5'd0, 1, 31'h0, 0, 0, 6'd0, 0, 0));
    vecs.push_back(mk(0, 0, 31'h0, 0, 5'd0,  0, 31'h0, 0, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd0,  0, 31'h1, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd1,  0, 31'h2, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd2,  0, 31'h3, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd3,  0, 31'h4, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd4,  0, 31'h5, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd5,  0, 31'h0, 0, 1, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd31, 0, 31'h0, 0, 1, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 1, 5'd2,  0, 31'h3, 1, 0, 6'd5, 1, 0));
    vecs.push_back(mk(0, 0, 31'h0, 0, 5'd0,  0, 31'h3, 0, 0, 6'd5, 1, 0));
    // Table B (16..25): prog+fetch priority, reload 2 words, empty load.
    vecs.push_back(mk(1, 0, 31'h0,  1, 5'd0, 0, 31'h40000001, 0, 1, 6'd32, 0, 0));
    vecs.push_back(mk(1, 1, 31'hAA, 0, 5'd0, 1, 31'h40000001, 0, 0, 6'd32, 0, 0));
    vecs.push_back(mk(1, 1, 31'hBB, 0, 5'd0, 1, 31'h40000001, 0, 0, 6'd32, 0, 0));
    vecs.push_back(mk(0, 0, 31'h0,  0, 5'd0, 0, 31'h40000001, 0, 0, 6'd2,  1, 0));
    vecs.push_back(mk(0, 0, 31'h0,  1, 5'd2, 0, 31'h0,        0, 1, 6'd2,  1, 0));
    vecs.push_back(mk(0, 0, 31'h0,  1, 5'd1, 0, 31'hBB,       1, 0, 6'd2,  1, 0));
    vecs.push_back(mk(1, 0, 31'h0,  0, 5'd0, 0, 31'hBB,       0, 0, 6'd2,  0, 0));
    vecs.push_back(mk(0, 0, 31'h0,  0, 5'd0, 0, 31'hBB,       0, 0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 31'h0,  1, 5'd0, 0, 31'hBB,       0, 1, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 31'h0,  0, 5'd0, 0, 31'hBB,       0, 0, 6'd0,  0, 0));

    // Reset state, then reset asserted in the middle of a load.
    rst = 1'b1;
    bus.prog = 0; bus.ld_valid = 0; bus.ld_word = '0; bus.fetch = 0; bus.pc = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst ld_ready", bus.ld_ready, 1'b0);
    chk_outs("rst", 31'h0, 0, 0, 6'd0, 0, 0);
    @(negedge clk) rst = 1'b0;
    drive(1, 0, 31'h0, 0, 5'd0);
    for (int k = 1; k <= 3; k++) drive(1, 1, 31'h7000 + IW'(k), 0, 5'd0);
    #1 chk("midload ld_ready", bus.ld_ready, 1'b1);
    @(negedge clk) rst = 1'b1;
    #1 chk("midrst ld_ready", bus.ld_ready, 1'b0);
    chk_outs("midrst", 31'h0, 0, 0, 6'd0, 0, 0);
    bus.prog = 0; bus.ld_valid = 0;
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 31'h0, 1, 5'd0);
    @(posedge clk);
    #1 chk_outs("rst fetch", 31'h0, 0, 1, 6'd0, 0, 0);

    run_vecs(0, 15);

    // Fill all 32 words, then one extra word must be refused and flag ovf.
    drive(1, 0, 31'h0, 0, 5'd0);
    @(posedge clk);
    #1 chk_outs("full enter", 31'h3, 0, 0, 6'd5, 0, 0);
    for (int i = 0; i < 33; i++) begin
      drive(1, 1, 31'h40000000 | IW'(i + 1), 0, 5'd0);
      #1 chk($sformatf("full w%0d ld_ready", i), bus.ld_ready, i < 32);
      @(posedge clk);
      #1 chk($sformatf("full w%0d ovf", i), bus.ovf, i == 32);
    end
    drive(0, 0, 31'h0, 0, 5'd0);
    @(posedge clk);
    #1 chk_outs("full done", 31'h3, 0, 0, 6'd32, 1, 1);
    drive(0, 0, 31'h0, 1, 5'd31);
    @(posedge clk);
    #1 chk_outs("full pc31", 31'h40000020, 1, 0, 6'd32, 1, 1);
    drive(0, 0, 31'h0, 1, 5'd0);
    @(posedge clk);
    #1 chk_outs("full pc0", 31'h40000001, 1, 0, 6'd32, 1, 1);

    run_vecs(16, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Program memory responder for the controller's instruction-fetch interface.
- Loaded word-by-word through a valid/ready programming port while `prog` is high.
- Serves `instr_word` one cycle after the controller asserts `fetch` with `pc`.
- Sits between the host load path and `top`, replacing the behavioural ROM used in simulation.

Parameters:
- VEC_ID_WIDTH, 3, vector id field width
- REGFILE_ADDR_WIDTH, 4, register file address width
- DATA_ADDR_WIDTH, 6, data/coef RAM address width
- PROG_SIZE, 32, program memory depth in words (power of 2)
- INSTR_WIDTH (localparam), 2+VEC_ID_WIDTH+2*REGFILE_ADDR_WIDTH+3*DATA_ADDR_WIDTH (=31), instruction word width
- PC_WIDTH (localparam), $clog2(PROG_SIZE), pc width

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- prog  in  1  load mode request (level)
- ld_valid  in  1  load word valid
- ld_word  in  INSTR_WIDTH  instruction word to store
- ld_ready  out  1  memory accepts a load word this cycle
- fetch  in  1  fetch request from controller
- pc  in  PC_WIDTH  fetch address
- instr_word  out  INSTR_WIDTH  fetched instruction, held between fetches
- instr_valid  out  1  one-cycle pulse: instr_word updated by a fetch
- addr_err  out  1  one-cycle pulse: fetch rejected
- prog_len  out  PC_WIDTH+1  number of words loaded
- loaded  out  1  memory holds a valid program
- ovf  out  1  sticky: load attempted while full

Behaviour:
- Reset (async, any time including mid-load):
  - state=EMPTY, wr_ptr=0.
  - All outputs 0: ld_ready, instr_word, instr_valid, addr_err, prog_len, loaded, ovf.
  - Memory array is not cleared; its contents are undefined after reset.
- States:
  - EMPTY: prog=1 -> LOAD, wr_ptr<=0, ovf<=0.
  - LOAD:
    - ld_ready = (wr_ptr < PROG_SIZE), combinational from state and wr_ptr.
    - On ld_valid&ld_ready: mem[wr_ptr]<=ld_word, wr_ptr<=wr_ptr+1.
    - On prog=0: prog_len<=wr_ptr. Go to READY with loaded<=1 if wr_ptr!=0; otherwise go to EMPTY with loaded<=0.
    - A handshake in the same cycle prog falls is not accepted; ld_ready is 0 whenever prog=0.
  - READY: prog=1 -> LOAD, wr_ptr<=0, loaded<=0, ovf<=0. prog has priority over a simultaneous fetch; that fetch is rejected (addr_err=1).
- Full condition: wr_ptr==PROG_SIZE -> ld_ready=0. Any ld_valid in that state sets ovf, which stays set until the next LOAD entry or reset. wr_ptr does not wrap.
- Fetch, latency 1: fetch sampled at posedge N; at posedge N+1 the response is one of:
  - READY and pc<prog_len: instr_word<=mem[pc], instr_valid<=1.
  - READY and pc>=prog_len: instr_word<=0, addr_err<=1, instr_valid<=0.
  - EMPTY or LOAD: instr_word held, addr_err<=1, instr_valid<=0.
- No fetch: instr_word holds its value; instr_valid=0, addr_err=0.
- Back-to-back fetches are supported every cycle, one response per request.
- No read-during-write hazard: reads are allowed only in READY and writes only in LOAD.
- Width rules:
  - prog_len and wr_ptr are PC_WIDTH+1 bits so that PROG_SIZE is representable.
  - The pc comparison zero-extends pc.

Decomposition:
- Shared package/header:
  - INSTR_WIDTH formula and field offsets (lstg_f, upse_f, vector_id, result_reg, error_reg, data/coef pointer fields), so this block, the controller fetch stage and the benches agree on layout.
  - State encoding constants S_EMPTY, S_LOAD, S_READY.
- Sub-module: prog_mem_ram, a single-port synchronous-write, registered-read array (PROG_SIZE x INSTR_WIDTH). It is the natural synthesis boundary for later BRAM mapping.
- FSM, pointer, flags and error logic stay in prog_mem.

Test Plan:
1. Reset mid-load: load 3 words, assert rst for 1 cycle -> all outputs 0, loaded=0. A following fetch pc=0 gives addr_err=1 and instr_word=0.
2. Load then fetch: load 5 words 0x1..0x5, drop prog -> prog_len=5, loaded=1. Fetches pc=0..4 on consecutive cycles return 0x1..0x5, each one cycle later, instr_valid=1.
3. Out of range: after scenario 2, fetch pc=5 and pc=31 -> instr_word=0, addr_err=1, instr_valid=0. Next fetch pc=2 returns 0x3.
4. Full: drive 33 ld_valid words -> ld_ready=0 after word 32, ovf=1, prog_len=32. Fetch pc=31 returns word 32.
5. Priority/reload: in READY assert prog and fetch together -> addr_err=1, loaded=0, state LOAD. Reload 2 words -> prog_len=2 and pc=2 is rejected.
6. Empty load: pulse prog with no ld_valid -> state EMPTY, loaded=0, prog_len=0. Fetch pc=0 gives addr_err=1 and instr_word held.
